// File: rtl/menu_controller.sv
// menu_controller: front-panel controller for the traffic-light VGA menu.
// Turns five debounced push-button levels into the menu cursor, three
// signal-timing settings and the STOP/PLAY/PAUSE run state.
// Optional feature macro: MENU_AUTOREPEAT_EN (inc/dec auto-repeat while held).
//
// Handshake: there is no valid/ready traffic; every output is a plain
// registered level, and sim_start/sim_stop/cfg_changed are single-cycle
// pulses that the consumer must sample on every clock.
module menu_controller #(
    parameter int GREEN_DEF     = 10,
    parameter int YELLOW_DEF    = 3,
    parameter int RED_DEF       = 2,
    parameter int DUR_MIN       = 1,
    parameter int DUR_MAX       = 99,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [3:0] menu_sel,
    output logic [7:0] green_duration,
    output logic [7:0] yellow_duration,
    output logic [7:0] red_holding,
    output logic [1:0] run_state,
    output logic       sim_start,
    output logic       sim_stop,
    output logic       cfg_changed
);

    typedef enum logic [1:0] {
        RUN_STOP  = 2'd0,
        RUN_PLAY  = 2'd1,
        RUN_PAUSE = 2'd2
    } run_e;

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_ENTER = 2;
    localparam int B_INC   = 3;
    localparam int B_DEC   = 4;

    localparam logic [7:0] GREEN_RST  = 8'(GREEN_DEF);
    localparam logic [7:0] YELLOW_RST = 8'(YELLOW_DEF);
    localparam logic [7:0] RED_RST    = 8'(RED_DEF);
    localparam logic [7:0] DUR_MIN_C  = 8'(DUR_MIN);
    localparam logic [7:0] DUR_MAX_C  = 8'(DUR_MAX);

    // Reject parameter sets the datapath cannot represent.
    if (DUR_MIN < 1 || DUR_MAX > 255 || DUR_MIN > DUR_MAX ||
        REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_param_check
        $error("menu_controller: inconsistent parameter set");
    end

    logic [4:0] btn_raw;
    logic [4:0] sync1_q;
    logic [4:0] sync2_q;
    logic [4:0] prev_q;
    logic [4:0] rise;
    logic       edge_any;

    logic       ev_up, ev_down, ev_enter, ev_inc, ev_dec;
    logic [3:0] sel_up, sel_down;
    logic       edit_ok;
    logic [7:0] cur_val;
    logic       step_ok;
    logic [7:0] step_val;

    run_e       run_q;
    logic [3:0] menu_sel_q;
    logic [7:0] green_q, yellow_q, red_q;
    logic       sim_start_q, sim_stop_q, cfg_changed_q;

    assign btn_raw = {btn_dec, btn_inc, btn_enter, btn_down, btn_up};

    // Two-flop synchronizer plus previous-value flop. All reset high so a
    // button held through reset release never looks like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~prev_q;
    assign edge_any = |rise;

`ifdef MENU_AUTOREPEAT_EN
    localparam logic [31:0] RPT_DELAY_C  = 32'(REPEAT_DELAY);
    localparam logic [31:0] RPT_RELOAD_C = 32'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic        rpt_arm_q;
    logic        rpt_inc_q;
    logic [31:0] rpt_cnt_q;
    logic        rpt_held;
    logic        rpt_fire;

    assign rpt_held = rpt_inc_q ? sync2_q[B_INC] : sync2_q[B_DEC];
    // A repeat only fires in a cycle with no fresh edge; any edge wins and
    // restarts or clears the counter below.
    assign rpt_fire = rpt_arm_q && rpt_held && !edge_any && (rpt_cnt_q == RPT_DELAY_C);

    // Repeat counter: armed by an accepted inc/dec edge, counts hold cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_arm_q <= 1'b0;
            rpt_inc_q <= 1'b0;
            rpt_cnt_q <= '0;
        end else if (edge_any) begin
            if (ev_inc || ev_dec) begin
                rpt_arm_q <= 1'b1;
                rpt_inc_q <= ev_inc;
                rpt_cnt_q <= 32'd1;
            end else begin
                rpt_arm_q <= 1'b0;
                rpt_cnt_q <= '0;
            end
        end else if (rpt_arm_q && rpt_held) begin
            rpt_cnt_q <= rpt_fire ? RPT_RELOAD_C : rpt_cnt_q + 32'd1;
        end else begin
            rpt_arm_q <= 1'b0;
            rpt_cnt_q <= '0;
        end
    end
`endif

    // Pick the single accepted event: enter > up > down > inc > dec.
    always_comb begin
        ev_up    = 1'b0;
        ev_down  = 1'b0;
        ev_enter = 1'b0;
        ev_inc   = 1'b0;
        ev_dec   = 1'b0;
        if (rise[B_ENTER])     ev_enter = 1'b1;
        else if (rise[B_UP])   ev_up    = 1'b1;
        else if (rise[B_DOWN]) ev_down  = 1'b1;
        else if (rise[B_INC])  ev_inc   = 1'b1;
        else if (rise[B_DEC])  ev_dec   = 1'b1;
`ifdef MENU_AUTOREPEAT_EN
        else if (rpt_fire) begin
            ev_inc = rpt_inc_q;
            ev_dec = !rpt_inc_q;
        end
`endif
    end

    // Cursor neighbours; heading lines 0, 4 and 5 are skipped.
    always_comb begin
        sel_up   = 4'd1;
        sel_down = 4'd1;
        case (menu_sel_q)
            4'd1: begin sel_up = 4'd8; sel_down = 4'd2; end
            4'd2: begin sel_up = 4'd1; sel_down = 4'd3; end
            4'd3: begin sel_up = 4'd2; sel_down = 4'd6; end
            4'd6: begin sel_up = 4'd3; sel_down = 4'd7; end
            4'd7: begin sel_up = 4'd6; sel_down = 4'd8; end
            4'd8: begin sel_up = 4'd7; sel_down = 4'd1; end
            default: begin sel_up = 4'd1; sel_down = 4'd1; end
        endcase
    end

    // Setting under the cursor and its saturated next value.
    always_comb begin
        edit_ok = (menu_sel_q >= 4'd1) && (menu_sel_q <= 4'd3) && (run_q != RUN_PLAY);
        case (menu_sel_q)
            4'd2:    cur_val = yellow_q;
            4'd3:    cur_val = red_q;
            default: cur_val = green_q;
        endcase
        step_ok  = edit_ok && ((ev_inc && (cur_val < DUR_MAX_C)) ||
                               (ev_dec && (cur_val > DUR_MIN_C)));
        step_val = ev_inc ? cur_val + 8'd1 : cur_val - 8'd1;
    end

    // Run-state FSM with cursor, settings and pulse outputs, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= RUN_STOP;
            menu_sel_q    <= 4'd1;
            green_q       <= GREEN_RST;
            yellow_q      <= YELLOW_RST;
            red_q         <= RED_RST;
            sim_start_q   <= 1'b0;
            sim_stop_q    <= 1'b0;
            cfg_changed_q <= 1'b0;
        end else begin
            sim_start_q   <= 1'b0;
            sim_stop_q    <= 1'b0;
            cfg_changed_q <= 1'b0;
            if (ev_enter) begin
                case (run_q)
                    RUN_STOP: begin
                        if (menu_sel_q == 4'd6) begin
                            run_q       <= RUN_PLAY;
                            sim_start_q <= 1'b1;
                        end
                    end
                    RUN_PLAY: begin
                        if (menu_sel_q == 4'd7) begin
                            run_q <= RUN_PAUSE;
                        end else if (menu_sel_q == 4'd8) begin
                            run_q      <= RUN_STOP;
                            sim_stop_q <= 1'b1;
                        end
                    end
                    RUN_PAUSE: begin
                        if (menu_sel_q == 4'd6) begin
                            run_q <= RUN_PLAY;
                        end else if (menu_sel_q == 4'd8) begin
                            run_q      <= RUN_STOP;
                            sim_stop_q <= 1'b1;
                        end
                    end
                    default: run_q <= RUN_STOP;
                endcase
            end else if (ev_up) begin
                menu_sel_q <= sel_up;
            end else if (ev_down) begin
                menu_sel_q <= sel_down;
            end else if (step_ok) begin
                case (menu_sel_q)
                    4'd1:    green_q  <= step_val;
                    4'd2:    yellow_q <= step_val;
                    default: red_q    <= step_val;
                endcase
                cfg_changed_q <= 1'b1;
            end
        end
    end

    assign menu_sel        = menu_sel_q;
    assign green_duration  = green_q;
    assign yellow_duration = yellow_q;
    assign red_holding     = red_q;
    assign run_state       = run_q;
    assign sim_start       = sim_start_q;
    assign sim_stop        = sim_stop_q;
    assign cfg_changed     = cfg_changed_q;

endmodule

// File: doc/menu_controller.md
# menu_controller

Sequential front-panel controller for the traffic-light VGA menu. Converts five debounced push-button levels into the menu cursor, the three signal-timing settings and the simulation run state. Drives the `menu_sel`, `green_duration`, `yellow_duration` and `red_holding` inputs of the text renderer. Drives the run-control pulses consumed by the traffic-light sequencer.

## Interface
- `GREEN_DEF`, 10: green duration after reset, seconds.
- `YELLOW_DEF`, 3: yellow duration after reset, seconds.
- `RED_DEF`, 2: red-holding time after reset, seconds.
- `DUR_MIN`, 1: lower saturation bound for all three settings.
- `DUR_MAX`, 99: upper saturation bound for all three settings (two display digits).
- `REPEAT_DELAY`, 50000000: hold cycles before first auto-repeat. Used only with the auto-repeat macro.
- `REPEAT_PERIOD`, 10000000: cycles between auto-repeats. Used only with the auto-repeat macro.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_enter`, `btn_inc`, `btn_dec`  in  1 each  debounced button levels, asynchronous to `clk`.
- `menu_sel`  out  4  cursor line: 1, 2, 3, 6, 7 or 8.
- `green_duration`, `yellow_duration`, `red_holding`  out  8 each  settings, binary.
- `run_state`  out  2  0 = STOP, 1 = PLAY, 2 = PAUSE.
- `sim_start`  out  1  one-cycle pulse on STOP→PLAY.
- `sim_stop`  out  1  one-cycle pulse on PLAY/PAUSE→STOP.
- `cfg_changed`  out  1  one-cycle pulse when any setting value changes.

## Operation
- Each button has a 2-flop synchronizer, then a rising-edge detector. The edge detector's previous-value flop resets to 1, so a button held through reset release produces no event.
- One event is accepted per cycle. Priority: enter > up > down > inc > dec. Lower-priority edges in the same cycle are dropped, not queued.
- Cursor:
  - Down steps 1→2→3→6→7→8→1.
  - Up steps 1→8→7→6→3→2→1.
  - Lines 0, 4 and 5 are headings and are never selected.
- Inc/dec act on the setting under the cursor when `menu_sel` is 1, 2 or 3 and `run_state` is STOP or PAUSE. They are ignored in PLAY and on lines 6–8.
- Inc at `DUR_MAX` and dec at `DUR_MIN` saturate. They leave the value unchanged and produce no `cfg_changed`.
- Run-state FSM on enter:
  - STOP + enter on line 6 → PLAY, `sim_start`.
  - PLAY + enter on line 7 → PAUSE.
  - PAUSE + enter on line 6 → PLAY, no `sim_start`.
  - PLAY or PAUSE + enter on line 8 → STOP, `sim_stop`.
  - All other enter combinations (including enter on lines 1–3) → no change.
- Reset values:
  - `menu_sel` = 1.
  - Settings = `GREEN_DEF`, `YELLOW_DEF`, `RED_DEF`.
  - `run_state` = 0.
  - All pulse outputs = 0.

## Timing
- All outputs are registered.
- A button first sampled high by the first synchronizer flop at edge k produces its effect on outputs at edge k+2. Pulses are high for exactly the cycle after edge k+2.
- `cfg_changed` asserts in the same cycle the new setting value appears.
- Back-to-back events on consecutive cycles are each honoured: release and re-press with a 1-cycle low still yields two events.
- Reset assertion clears every register immediately, including mid-pulse and mid-repeat. No pending event survives reset.

## Configuration
- Macro: `MENU_AUTOREPEAT_EN`.
- Defined:
  - While the synchronized `btn_inc` or `btn_dec` stays high, a repeat counter runs.
  - The first repeat event is generated `REPEAT_DELAY` cycles after the initial edge. Further events follow every `REPEAT_PERIOD` cycles.
  - Repeat events obey the same priority, run-state gating and saturation rules as edge events.
  - Releasing the button, or any higher-priority edge, clears the counter.
  - Up/down/enter never repeat.
- Undefined: no repeat counter is built. One step per press, and `REPEAT_*` are unused.

## Test plan
- Reset with `btn_enter` held, then release `rst_n` → outputs show 1/10/3/2/STOP, and no event fires until enter is released and re-pressed.
- 6 × down pulses from reset → `menu_sel` 2, 3, 6, 7, 8, 1. Then 1 × up → 8.
- Cursor on 2, 5 × dec from 3 → yellow 2, 1, 1, 1, 1, with `cfg_changed` on the first two presses only. Green at 98 plus 3 × inc → 99, with one `cfg_changed`.
- Select 6 + enter → PLAY, `sim_start` one cycle. Inc on line 1 → green unchanged. Select 7 + enter → PAUSE. Inc → green 11. Select 6 + enter → PLAY with no `sim_start`. Select 8 + enter → STOP with `sim_stop`.
- `btn_down` and `btn_inc` edges in the same cycle with cursor on 1 → `menu_sel` becomes 2, green stays 10.
- With `MENU_AUTOREPEAT_EN`, `REPEAT_DELAY` = 20, `REPEAT_PERIOD` = 5: hold inc on line 1 for 40 cycles → green 10→11 at the edge, then +1 at 20, 25, 30 and 35 cycles after the edge, final 15.
